// File: rtl/div_request_arbiter.sv
// ---------------------------------------------------------------------------
// div_request_arbiter
//
// Initiator side of the shared RV32M divide/remainder unit. Four cores present
// DIV/DIVU/REM/REMU requests; one is granted per cycle in round-robin order.
// Granted requests are issued to the divide unit, and per-core result pulses are
// routed back to the core that issued them. Divide-by-zero and signed overflow
// are resolved here and never reach the unit.
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   asynchronous, active-low reset
//   core_req_valid   in   [3:0]    per-core request valid
//   core_order       in   [7:0]    per-core op [2i+1:2i]: bit0 unsigned, bit1 remainder
//   core_rs1/rs2     in   [127:0]  per-core operands [32i+31:32i]
//   core_accept      out  [3:0]    one-cycle pulse, request of core i captured
//   core_resp_valid  out  [3:0]    one-cycle pulse, result for core i valid
//   core_resp_data   out  [127:0]  per-core result, held until next response
//   core_busy        out  [3:0]    core i waiting on the divide unit
//   div_request      out           issue strobe to the divide unit
//   div_core_num     out  [2:0]    issued core number (bit 2 always 0)
//   div_order        out  [1:0]    issued op code
//   div_rs1/rs2      out  [31:0]   issued operands
//   div_ready        in   [3:0]    per-core result pulse from the divide unit
//   div_ans          in   [127:0]  per-core result from the divide unit
//   protocol_err     out           sticky: div_ready seen for a core not waiting
// ---------------------------------------------------------------------------
module div_request_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   core_req_valid,
    input  logic [7:0]   core_order,
    input  logic [127:0] core_rs1,
    input  logic [127:0] core_rs2,
    output logic [3:0]   core_accept,
    output logic [3:0]   core_resp_valid,
    output logic [127:0] core_resp_data,
    output logic         div_request,
    output logic [2:0]   div_core_num,
    output logic [1:0]   div_order,
    output logic [31:0]  div_rs1,
    output logic [31:0]  div_rs2,
    input  logic [3:0]   div_ready,
    input  logic [127:0] div_ans,
    output logic [3:0]   core_busy,
    output logic         protocol_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       state_q [4];
    state_t       state_d [4];
    logic [1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]   accept_q, accept_d;
    logic [127:0] resp_data_q, resp_data_d;
    logic         div_request_q, div_request_d;
    logic [2:0]   div_core_num_q, div_core_num_d;
    logic [1:0]   div_order_q, div_order_d;
    logic [31:0]  div_rs1_q, div_rs1_d;
    logic [31:0]  div_rs2_q, div_rs2_d;
    logic         protocol_err_q, protocol_err_d;

    // Returns {found, index} of the first set bit of elig searching upward
    // (mod 4) from ptr. Scanning from the far end lets the nearest hit win.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
        logic [1:0] cand;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (elig[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration and bypass decode on the granted request
    // ------------------------------------------------------------------
    logic [3:0]  eligible;
    logic [2:0]  pick;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [1:0]  g_order;
    logic [31:0] g_rs1, g_rs2;
    logic        div_by_zero, overflow, bypass;
    logic [31:0] bypass_data;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i]        = core_req_valid[i] && (state_q[i] == ST_IDLE);
            core_resp_valid[i] = (state_q[i] == ST_RESP);
            core_busy[i]       = (state_q[i] == ST_WAIT);
        end
    end

    assign pick        = rr_pick(eligible, rr_ptr_q);
    assign grant_valid = pick[2];
    assign grant_idx   = pick[1:0];
    assign g_order     = core_order[{grant_idx, 1'b0} +: 2];
    assign g_rs1       = core_rs1[{grant_idx, 5'b0} +: 32];
    assign g_rs2       = core_rs2[{grant_idx, 5'b0} +: 32];

    // Division by zero takes precedence; overflow only exists for signed ops.
    assign div_by_zero = (g_rs2 == 32'h0);
    assign overflow    = !g_order[0] && (g_rs1 == 32'h8000_0000) && (g_rs2 == 32'hFFFF_FFFF);
    assign bypass      = div_by_zero || overflow;

    always_comb begin
        if (div_by_zero) bypass_data = g_order[1] ? g_rs1 : 32'hFFFF_FFFF;
        else             bypass_data = g_order[1] ? 32'h0 : 32'h8000_0000;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned,
        // which would otherwise infer a latch.
        resp_data_d    = resp_data_q;
        accept_d       = 4'b0;
        rr_ptr_d       = rr_ptr_q;
        div_request_d  = 1'b0;
        div_core_num_d = div_core_num_q;
        div_order_d    = div_order_q;
        div_rs1_d      = div_rs1_q;
        div_rs2_d      = div_rs2_q;
        protocol_err_d = protocol_err_q;

        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (grant_valid && (grant_idx == 2'(i))) begin
                        accept_d[i] = 1'b1;
                        if (bypass) begin
                            state_d[i]            = ST_RESP;
                            resp_data_d[32*i +: 32] = bypass_data;
                        end else begin
                            state_d[i] = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (div_ready[i]) begin
                        state_d[i]            = ST_RESP;
                        resp_data_d[32*i +: 32] = div_ans[32*i +: 32];
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase

            // A result for a core that is not waiting is dropped and flagged.
            if (div_ready[i] && (state_q[i] != ST_WAIT)) protocol_err_d = 1'b1;
        end

        if (grant_valid) begin
            rr_ptr_d = grant_idx + 2'd1;
            if (!bypass) begin
                div_request_d  = 1'b1;
                div_core_num_d = {1'b0, grant_idx};
                div_order_d    = g_order;
                div_rs1_d      = g_rs1;
                div_rs2_d      = g_rs2;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) state_q[i] <= ST_IDLE;
            rr_ptr_q       <= 2'd0;
            accept_q       <= 4'b0;
            // NOTE: the result holding registers are reset too, since their
            // values are visible on core_resp_data straight out of reset.
            resp_data_q    <= 128'h0;
            div_request_q  <= 1'b0;
            div_core_num_q <= 3'd0;
            div_order_q    <= 2'd0;
            div_rs1_q      <= 32'h0;
            div_rs2_q      <= 32'h0;
            protocol_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
            rr_ptr_q       <= rr_ptr_d;
            accept_q       <= accept_d;
            resp_data_q    <= resp_data_d;
            div_request_q  <= div_request_d;
            div_core_num_q <= div_core_num_d;
            div_order_q    <= div_order_d;
            div_rs1_q      <= div_rs1_d;
            div_rs2_q      <= div_rs2_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign core_accept    = accept_q;
    assign core_resp_data = resp_data_q;
    assign div_request    = div_request_q;
    assign div_core_num   = div_core_num_q;
    assign div_order      = div_order_q;
    assign div_rs1        = div_rs1_q;
    assign div_rs2        = div_rs2_q;
    assign protocol_err   = protocol_err_q;

endmodule

// File: tb/tb_div_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_request_arbiter
//
// Directed bench for div_request_arbiter. The bench plays the role of the four
// cores and of the divide unit; divide results are hand-computed constants.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_div_request_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   core_req_valid;
    logic [7:0]   core_order;
    logic [127:0] core_rs1;
    logic [127:0] core_rs2;
    logic [3:0]   core_accept;
    logic [3:0]   core_resp_valid;
    logic [127:0] core_resp_data;
    logic         div_request;
    logic [2:0]   div_core_num;
    logic [1:0]   div_order;
    logic [31:0]  div_rs1;
    logic [31:0]  div_rs2;
    logic [3:0]   div_ready;
    logic [127:0] div_ans;
    logic [3:0]   core_busy;
    logic         protocol_err;

    int checks = 0;
    int errors = 0;

    div_request_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .core_req_valid  (core_req_valid),
        .core_order      (core_order),
        .core_rs1        (core_rs1),
        .core_rs2        (core_rs2),
        .core_accept     (core_accept),
        .core_resp_valid (core_resp_valid),
        .core_resp_data  (core_resp_data),
        .div_request     (div_request),
        .div_core_num    (div_core_num),
        .div_order       (div_order),
        .div_rs1         (div_rs1),
        .div_rs2         (div_rs2),
        .div_ready       (div_ready),
        .div_ans         (div_ans),
        .core_busy       (core_busy),
        .protocol_err    (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        core_req_valid[c]    = 1'b1;
        core_order[2*c +: 2] = op;
        core_rs1[32*c +: 32] = a;
        core_rs2[32*c +: 32] = b;
    endtask

    // Divide unit returns a result for core c; one cycle later is the RESP cycle.
    task automatic respond(input int c, input logic [31:0] ans);
        div_ready[c]        = 1'b1;
        div_ans[32*c +: 32] = ans;
        tick();
        div_ready = 4'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_accept"},  128'(core_accept),     128'h0);
        check({tag, "_rvalid"},  128'(core_resp_valid), 128'h0);
        check({tag, "_busy"},    128'(core_busy),       128'h0);
        check({tag, "_divreq"},  128'(div_request),     128'h0);
        check({tag, "_err"},     128'(protocol_err),    128'h0);
        check({tag, "_rdata"},   core_resp_data,        128'h0);
        check({tag, "_corenum"}, 128'(div_core_num),    128'h0);
        check({tag, "_order"},   128'(div_order),       128'h0);
        check({tag, "_rs1"},     128'(div_rs1),         128'h0);
        check({tag, "_rs2"},     128'(div_rs2),         128'h0);
    endtask

    initial begin
        reset          = 1'b0;
        core_req_valid = 4'b0;
        core_order     = 8'h0;
        core_rs1       = 128'h0;
        core_rs2       = 128'h0;
        div_ready      = 4'b0;
        div_ans        = 128'h0;

        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b1;
        tick();

        // ---- core0 DIVU 100/7 -> 14 ----
        set_req(0, 2'b01, 32'd100, 32'd7);
        tick();
        check("c0_accept",  128'(core_accept),  128'h1);
        check("c0_divreq",  128'(div_request),  128'h1);
        check("c0_corenum", 128'(div_core_num), 128'h0);
        check("c0_order",   128'(div_order),    128'h1);
        check("c0_rs1",     128'(div_rs1),      128'd100);
        check("c0_rs2",     128'(div_rs2),      128'd7);
        check("c0_busy",    128'(core_busy),    128'h1);
        core_req_valid = 4'b0;
        tick();
        check("c0_divreq_drop", 128'(div_request), 128'h0);
        check("c0_accept_drop", 128'(core_accept), 128'h0);
        check("c0_rs1_hold",    128'(div_rs1),     128'd100);
        check("c0_busy_hold",   128'(core_busy),   128'h1);
        respond(0, 32'd14);
        check("c0_rvalid", 128'(core_resp_valid),     128'h1);
        check("c0_rdata",  128'(core_resp_data[31:0]), 128'd14);
        check("c0_busy_end", 128'(core_busy),         128'h0);
        tick();
        check("c0_rvalid_drop", 128'(core_resp_valid), 128'h0);

        // ---- core2 signed DIV and REM of -100 by 7 ----
        set_req(2, 2'b00, 32'hFFFF_FF9C, 32'd7);
        tick();
        check("c2div_accept",  128'(core_accept),  128'h4);
        check("c2div_corenum", 128'(div_core_num), 128'h2);
        check("c2div_order",   128'(div_order),    128'h0);
        check("c2div_rs1",     128'(div_rs1),      128'hFFFF_FF9C);
        core_req_valid = 4'b0;
        respond(2, 32'hFFFF_FFF2);
        check("c2div_rvalid", 128'(core_resp_valid),       128'h4);
        check("c2div_rdata",  128'(core_resp_data[95:64]), 128'hFFFF_FFF2);
        tick();
        set_req(2, 2'b10, 32'hFFFF_FF9C, 32'd7);
        tick();
        check("c2rem_divreq", 128'(div_request), 128'h1);
        check("c2rem_order",  128'(div_order),   128'h2);
        core_req_valid = 4'b0;
        respond(2, 32'hFFFF_FFFE);
        check("c2rem_rdata", 128'(core_resp_data[95:64]), 128'hFFFF_FFFE);
        tick();

        // ---- bypass cases on core1 ----
        set_req(1, 2'b01, 32'd55, 32'd0);
        tick();
        check("bp_divu0_accept", 128'(core_accept),           128'h2);
        check("bp_divu0_rvalid", 128'(core_resp_valid),       128'h2);
        check("bp_divu0_divreq", 128'(div_request),           128'h0);
        check("bp_divu0_rdata",  128'(core_resp_data[63:32]), 128'hFFFF_FFFF);
        core_req_valid = 4'b0;
        tick();
        check("bp_divu0_idle", 128'(core_resp_valid), 128'h0);

        set_req(1, 2'b10, 32'h1234_5678, 32'd0);
        tick();
        check("bp_rem0_accept", 128'(core_accept),           128'h2);
        check("bp_rem0_rvalid", 128'(core_resp_valid),       128'h2);
        check("bp_rem0_divreq", 128'(div_request),           128'h0);
        check("bp_rem0_rdata",  128'(core_resp_data[63:32]), 128'h1234_5678);
        core_req_valid = 4'b0;
        tick();

        set_req(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        check("bp_ovf_accept", 128'(core_accept),           128'h2);
        check("bp_ovf_rvalid", 128'(core_resp_valid),       128'h2);
        check("bp_ovf_divreq", 128'(div_request),           128'h0);
        check("bp_ovf_rdata",  128'(core_resp_data[63:32]), 128'h8000_0000);
        core_req_valid = 4'b0;
        tick();

        // Same operands unsigned: no overflow path, goes to the unit.
        set_req(1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        check("divu_ovfpat_divreq", 128'(div_request),     128'h1);
        check("divu_ovfpat_rvalid", 128'(core_resp_valid), 128'h0);
        check("divu_ovfpat_busy",   128'(core_busy),       128'h2);
        core_req_valid = 4'b0;
        respond(1, 32'h0);
        check("divu_ovfpat_rdata", 128'(core_resp_data[63:32]), 128'h0);
        tick();

        // core3 bypass: rr_ptr goes from 2 to 0.
        set_req(3, 2'b01, 32'd5, 32'd0);
        tick();
        check("bp_c3_rdata", 128'(core_resp_data[127:96]), 128'hFFFF_FFFF);
        core_req_valid = 4'b0;
        tick();

        // ---- round robin, all four cores at once ----
        for (int c = 0; c < 4; c++) set_req(c, 2'b01, 32'(10 * (c + 1)), 32'd1);
        tick();
        check("rr0_accept",  128'(core_accept),  128'h1);
        check("rr0_corenum", 128'(div_core_num), 128'h0);
        check("rr0_divreq",  128'(div_request),  128'h1);
        core_req_valid[0] = 1'b0;
        tick();
        check("rr1_accept",  128'(core_accept),  128'h2);
        check("rr1_corenum", 128'(div_core_num), 128'h1);
        check("rr1_divreq",  128'(div_request),  128'h1);
        core_req_valid[1] = 1'b0;
        tick();
        check("rr2_accept",  128'(core_accept),  128'h4);
        check("rr2_corenum", 128'(div_core_num), 128'h2);
        core_req_valid[2] = 1'b0;
        tick();
        check("rr3_accept",  128'(core_accept),  128'h8);
        check("rr3_corenum", 128'(div_core_num), 128'h3);
        check("rr3_rs1",     128'(div_rs1),      128'd40);
        core_req_valid = 4'b0;
        tick();
        check("rr_idle_divreq", 128'(div_request), 128'h0);
        check("rr_busy_all",    128'(core_busy),   128'hF);
        div_ready = 4'hF;
        div_ans   = {32'h103, 32'h102, 32'h101, 32'h100};
        tick();
        div_ready = 4'b0;
        check("rr_rvalid_all", 128'(core_resp_valid), 128'hF);
        check("rr_rdata_all",  core_resp_data, {32'h103, 32'h102, 32'h101, 32'h100});
        tick();

        // Second round: cores 0 and 3, rr_ptr back at 0.
        set_req(0, 2'b01, 32'd8, 32'd2);
        set_req(3, 2'b01, 32'd9, 32'd3);
        tick();
        check("rrb0_corenum", 128'(div_core_num), 128'h0);
        check("rrb0_accept",  128'(core_accept),  128'h1);
        core_req_valid[0] = 1'b0;
        tick();
        check("rrb3_corenum", 128'(div_core_num), 128'h3);
        check("rrb3_accept",  128'(core_accept),  128'h8);
        core_req_valid = 4'b0;
        div_ready = 4'h9;
        div_ans   = {32'd3, 32'h0, 32'h0, 32'd4};
        tick();
        div_ready = 4'b0;
        check("rrb_rvalid", 128'(core_resp_valid),         128'h9);
        check("rrb_rdata3", 128'(core_resp_data[127:96]),  128'd3);
        check("rrb_rdata0", 128'(core_resp_data[31:0]),    128'd4);
        tick();

        // ---- spurious div_ready for idle core3 ----
        check("pre_spur_err", 128'(protocol_err), 128'h0);
        respond(3, 32'hDEAD_BEEF);
        check("spur_rvalid", 128'(core_resp_valid),        128'h0);
        check("spur_rdata",  128'(core_resp_data[127:96]), 128'd3);
        check("spur_err",    128'(protocol_err),           128'h1);
        tick();
        tick();
        check("spur_err_sticky", 128'(protocol_err), 128'h1);

        // ---- reset while core1 waits ----
        set_req(1, 2'b01, 32'd200, 32'd10);
        tick();
        check("mid_busy", 128'(core_busy), 128'h2);
        core_req_valid = 4'b0;
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        reset = 1'b1;
        set_req(1, 2'b01, 32'd200, 32'd10);
        tick();
        check("post_accept",  128'(core_accept),  128'h2);
        check("post_divreq",  128'(div_request),  128'h1);
        check("post_corenum", 128'(div_core_num), 128'h1);
        check("post_rs1",     128'(div_rs1),      128'd200);
        core_req_valid = 4'b0;
        respond(1, 32'd20);
        check("post_rvalid", 128'(core_resp_valid),       128'h2);
        check("post_rdata",  128'(core_resp_data[63:32]), 128'd20);
        check("post_err",    128'(protocol_err),          128'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_request_arbiter.md
# div_request_arbiter

Initiator side of the shared RV32M divide/remainder unit. Accepts DIV/DIVU/REM/REMU requests from four cores and grants one per cycle by round-robin. Issues granted requests on the unit's request port and routes each per-core result pulse back to the originating core. Resolves divide-by-zero and signed overflow locally, without occupying the unit.

## Interface
- Parameters: none (4 cores, 32-bit operands, fixed).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- core_req_valid  in  4  per-core request valid; bit i = core i.
- core_order  in  8  per-core op, [2i+1:2i]: 00 DIV, 01 DIVU, 10 REM, 11 REMU (bit0 = unsigned, bit1 = remainder).
- core_rs1, core_rs2  in  128 each  per-core operands, [32i+31:32i].
- core_accept  out  4  one-cycle pulse: request of core i captured.
- core_resp_valid  out  4  one-cycle pulse: result for core i valid.
- core_resp_data  out  128  per-core result, held until next response.
- div_request  out  1  issue strobe to divide unit.
- div_core_num  out  3  target core; bit 2 always 0.
- div_order  out  2  op code, same encoding as core_order.
- div_rs1, div_rs2  out  32 each  issued operands.
- div_ready  in  4  per-core result pulse from divide unit.
- div_ans  in  128  per-core result from divide unit, [32i+31:32i].
- core_busy  out  4  bit i high while core i is in WAIT.
- protocol_err  out  1  sticky error flag; cleared only by reset.

## Operation
- Per-core FSM, 3 states:
  - IDLE: eligible for grant when core_req_valid[i]=1.
  - IDLE→WAIT: on a normal grant.
  - IDLE→RESP: on a bypass grant.
  - WAIT→RESP: when div_ready[i]=1; div_ans[i] is loaded into core_resp_data[i].
  - RESP→IDLE: unconditional.
  - core_resp_valid[i] = (state==RESP).
- Arbiter: at most one grant per cycle among IDLE cores with valid set.
  - Search order starts at rr_ptr (2 bits, reset 0).
  - On any grant to core g, rr_ptr ← g+1 mod 4. No grant leaves rr_ptr unchanged.
- Bypass, evaluated on the granted request:
  - rs2==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow, rs1==0x80000000 and rs2==0xFFFFFFFF: DIV → 0x80000000; REM → 0x00000000.
  - Unsigned ops never take the overflow path.
  - A bypass grant loads core_resp_data[g] directly and does not assert div_request.
- Normal grant: issue registers load div_core_num={1'b0,g}, div_order, div_rs1, div_rs2, and div_request=1 for exactly one cycle. Issue data registers hold their values while div_request=0.
- div_request is 0 in every cycle without a normal grant. Back-to-back issues to different cores are legal.
- A core has at most one outstanding request. This guarantees the unit's per-core result slot never carries two results.
- div_ready[i] while core i is not in WAIT: ignored (no state or data change) and sets protocol_err.
- Core-side rule: core_req_valid[i] is sampled only in IDLE. A core that has seen core_accept[i] must hold valid low from the next cycle on, unless it is presenting a new request.
- Divide-unit results for different cores may arrive in any order and in the same cycle. Each is handled independently.

## Timing
- Request at cycle N (core IDLE, wins arbitration):
  - Cycle N+1: core_accept pulse.
  - Normal grant: div_request pulse also in N+1.
  - Bypass grant: core_resp_valid also in N+1, then IDLE in N+2.
- div_ready[i] in cycle M → core_resp_valid[i] in M+1. The divide unit's latency is not assumed; results are accepted whenever div_ready arrives.
- Earliest re-grant of the same core: cycle after its RESP cycle.
- Reset values: all states IDLE; rr_ptr 0; core_accept, core_resp_valid, core_busy, div_request, protocol_err 0; core_resp_data, div_core_num, div_order, div_rs1, div_rs2 all 0.
- Reset mid-operation: all outstanding requests are dropped. div_ready pulses arriving after reset release for cores in IDLE are ignored and set protocol_err. The bench applies reset to the divide unit together with this block.

## Test plan
- Core0 DIVU rs1=100, rs2=7: div_request with core_num 0, order 01 in N+1; later core_resp_valid[0] with data 14; core_busy[0] high from N+1 until the RESP cycle.
- Core2 DIV rs1=0xFFFFFF9C (−100), rs2=7: core_resp_data[2]=0xFFFFFFF2 (−14). Same core REM: 0xFFFFFFFE (−2).
- Bypass: core1 DIVU x/0 → 0xFFFFFFFF; core1 REM 0x12345678/0 → 0x12345678; DIV 0x80000000/0xFFFFFFFF → 0x80000000. Each with accept and resp_valid both in N+1 and no div_request.
- All four cores valid in the same cycle, rr_ptr=0: grants in order 0,1,2,3 on consecutive cycles, one div_request each. Next round with core0 and core3 valid and rr_ptr=0 grants 0 then 3.
- Spurious div_ready[3] while core3 IDLE: no resp_valid, core_resp_data[3] unchanged, protocol_err=1 and held until reset.
- Reset asserted while core1 is in WAIT: all outputs at reset values immediately. After release, core1 accepts a new request and returns its correct result.
